fp_add_arbiter: RTL and testbench
=================================

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001: Parameter NREQ, default 4, number of requesters sharing one adder (2..8).
REQ-002: Parameter IDW, default $clog2(NREQ), requester-index width.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: req_valid  input  NREQ  per-requester operation request.
REQ-006: req_ready  output  NREQ  per-requester grant; at most one bit set.
REQ-007: req_a, req_b  input  NREQ x 32  per-requester IEEE-754 single operands.
REQ-008: req_sub  input  NREQ  per-requester op select (1 = A-B, 0 = A+B).
REQ-009: rsp_valid  output  NREQ  result ready for the indicated requester; at most one bit set.
REQ-010: rsp_ready  input  NREQ  per-requester result acceptance.
REQ-011: rsp_data  output  32  shared result bus, meaningful only while any rsp_valid bit is set.
REQ-012: rsp_id  output  IDW  index of the requester owning rsp_data.

Function
REQ-013: Shall instantiate one fpAdder32 as the only arithmetic resource; operands and op_sub come from the granted requester.
REQ-014: Transfer on request side occurs when req_valid[i] && req_ready[i]; on response side when rsp_valid[i] && rsp_ready[i].
REQ-015: Arbitration round-robin: search starts at (last_grant+1) mod NREQ, wraps, first valid wins; last_grant updates only on a transfer.
REQ-016: req_ready is combinational from req_valid, the pointer and slot state; it is never asserted while the result slot is full and not draining in the same cycle.
REQ-017: Result slot FSM states EMPTY and FULL; EMPTY->FULL on a request transfer; FULL->EMPTY on response transfer with no new request transfer; FULL->FULL on simultaneous response and request transfer (back-to-back).
REQ-018: Latency: result visible on rsp_data/rsp_valid the cycle after the request transfer; sustained throughput one operation per cycle when the owner accepts immediately.
REQ-019: rsp_data, rsp_id and rsp_valid shall hold stable while FULL and unaccepted, regardless of request-side activity.
REQ-020: rsp_ready bits other than rsp_id's shall be ignored.
REQ-021: A requester dropping req_valid without a transfer loses no state; a requester whose result is pending may be granted again only after (or in the same cycle as) its response transfer.
REQ-022: Starvation bound: a continuously valid requester is granted within NREQ transfers.

Reset
REQ-023: While rst_n low: slot EMPTY, rsp_valid 0, rsp_data 0, rsp_id 0, last_grant NREQ-1 (requester 0 has first priority), req_ready 0.
REQ-024: Reset asserted mid-operation discards any held result; no rsp_valid pulse follows reset release.

Configuration
REQ-025: Macro FP_ADD_ARB_PIPE_EN: when defined, granted operands are registered before the adder, adding one stage; latency becomes 2 cycles, throughput stays 1/cycle, stage advances only if the result slot is EMPTY or draining.
REQ-026: Without FP_ADD_ARB_PIPE_EN, adder is fed combinationally from the granted requester, latency 1 cycle.

Structure
REQ-027: Shared package fp_pkg holds fp32_t (32-bit typedef), FP_ONE/FP_TWO/FP_THREE constants and the slot-state enum.
REQ-028: One sub-module rr_arbiter (parameter NREQ; inputs req, advance; output one-hot grant and index) implements REQ-015.

Verification
REQ-029: Single request: req 0 a=0x3F800000 b=0x40000000 sub=0 -> next cycle rsp_valid=0001, rsp_id=0, rsp_data=0x40400000.
REQ-030: Subtraction: req 2 a=0x40400000 b=0x3F800000 sub=1 -> rsp_data=0x40000000 on rsp_id=2.
REQ-031: All four valid continuously, rsp_ready all 1 -> grant order 0,1,2,3,0,... one transfer per cycle, no gaps.
REQ-032: Backpressure: rsp_ready[1]=0 for 5 cycles with result pending -> rsp_data/rsp_id stable, req_ready all 0, no transfers until release.
REQ-033: Reset asserted one cycle after a transfer -> rsp_valid stays 0 through and after release; first post-reset grant goes to requester 0.
REQ-034: With FP_ADD_ARB_PIPE_EN defined, repeat REQ-029 and REQ-031 -> same data, latency 2, throughput unchanged.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared single-precision types, constants and the result-slot
//               state encoding for the shared FP adder arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP_ONE   = 32'h3F80_0000;
  localparam fp32_t FP_TWO   = 32'h4000_0000;
  localparam fp32_t FP_THREE = 32'h4040_0000;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/fpAdder32.sv
`default_nettype none
// ============================================================================
// Module      : fpAdder32
// Description : Combinational IEEE-754 single-precision adder/subtractor,
//               round-to-nearest-even, subnormal inputs and outputs supported,
//               NaN/Inf propagated.
// Revision    : 1.0 - initial release
// ============================================================================
module fpAdder32
  import fp_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  input  logic  op_sub,
  output fp32_t result
);

  fp32_t       bb, x, y;
  logic [7:0]  ex, ey, dexp;
  logic [26:0] mx, my, my_sh, n;
  logic        sticky, eff_sub, found;
  logic        x_nan, x_inf, y_inf;
  logic [27:0] s;
  logic [9:0]  e, sh;
  logic [4:0]  lz;
  logic [24:0] mr;

  // Order by magnitude, align the smaller operand, add/subtract, normalise, round
  always_comb begin
    bb = {b[31] ^ op_sub, b[30:0]};
    if (a[30:0] < bb[30:0]) begin
      x = bb;
      y = a;
    end else begin
      x = a;
      y = bb;
    end
    ex   = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey   = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx   = {x[30:23] != 8'd0, x[22:0], 3'b000};
    my   = {y[30:23] != 8'd0, y[22:0], 3'b000};
    dexp = ex - ey;
    if (dexp >= 8'd27) begin
      my_sh  = 27'd0;
      sticky = |my;
    end else begin
      my_sh  = my >> dexp;
      sticky = |(my & ~({27{1'b1}} << dexp));
    end
    my_sh[0] = my_sh[0] | sticky;
    eff_sub  = x[31] ^ y[31];
    s = eff_sub ? ({1'b0, mx} - {1'b0, my_sh}) : ({1'b0, mx} + {1'b0, my_sh});

    e     = {2'b00, ex};
    lz    = 5'd0;
    found = 1'b0;
    sh    = 10'd0;
    if (s[27]) begin
      n = s[27:1] | {26'd0, s[0]};
      e = e + 10'd1;
    end else begin
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (s[i]) found = 1'b1;
          else      lz    = lz + 5'd1;
        end
      end
      // Never normalise below the minimum exponent: the result goes subnormal
      sh = ({5'd0, lz} >= e) ? (e - 10'd1) : {5'd0, lz};
      n  = s[26:0] << sh;
      e  = e - sh;
    end

    mr = {1'b0, n[26:3]} + {24'd0, n[2] & (n[1] | n[0] | n[3])};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'd1;
    end

    x_nan = (&x[30:23]) && (x[22:0] != 23'd0);
    x_inf = (&x[30:23]) && (x[22:0] == 23'd0);
    y_inf = (y[30:0] == 31'h7F80_0000);

    if (x_nan || (x_inf && y_inf && eff_sub))
      result = 32'h7FC0_0000;
    else if (x_inf)
      result = x;
    else if (e >= 10'd255)
      result = {x[31], 8'hFF, 23'd0};
    else if (mr[23:0] == 24'd0)
      result = {x[31] & ~eff_sub, 31'd0};   // exact cancellation yields +0
    else
      result = {x[31], (mr[23] ? e[7:0] : 8'd0), mr[22:0]};
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Search starts one past the last granted
//               requester and wraps; the pointer only moves on 'advance'.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic [IDW-1:0] last_grant;
  logic           found;
  int             k;

  // First active requester after the pointer, wrapping around
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int off = 1; off <= NREQ; off++) begin
      k = (int'(last_grant) + off) % NREQ;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IDW'(k);
      end
    end
  end

  // Pointer resets to the last index so requester 0 has first priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_grant <= IDW'(NREQ - 1);
    else if (advance) last_grant <= idx;
  end

endmodule
`default_nettype wire

// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_arbiter
// Description : NREQ requesters share one fpAdder32 through a round-robin
//               arbiter and a single-entry result slot. Define
//               FP_ADD_ARB_PIPE_EN to register granted operands ahead of the
//               adder (latency 2, throughput unchanged).
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_arbiter
  import fp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][31:0] req_a,
  input  logic [NREQ-1:0][31:0] req_b,
  input  logic [NREQ-1:0]       req_sub,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output fp32_t                 rsp_data,
  output logic [IDW-1:0]        rsp_id
);

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  slot_state_t     slot;
  logic            drain, slot_open, xfer, load;
  logic [NREQ-1:0] slot_pend, pend_mask, arb_req, grant;
  logic [IDW-1:0]  gnt_idx, load_id;
  fp32_t           add_a, add_b, sum;
  logic            add_sub;

  // Only the owner's rsp_ready bit can drain the slot
  assign drain     = (slot == SLOT_FULL) && rsp_ready[rsp_id];
  assign slot_open = (slot == SLOT_EMPTY) || drain;
  assign rsp_valid = (slot == SLOT_FULL) ? (ONE_HOT0 << rsp_id) : '0;
  // A requester with an undrained result may not be granted again yet
  assign slot_pend = (slot == SLOT_FULL && !drain) ? (ONE_HOT0 << rsp_id) : '0;
  assign arb_req   = req_valid & ~pend_mask;
  assign xfer      = |req_ready;

`ifdef FP_ADD_ARB_PIPE_EN
  logic           st_valid, st_sub, stage_open;
  fp32_t          st_a, st_b;
  logic [IDW-1:0] st_id;

  assign load       = st_valid && slot_open;
  assign stage_open = !st_valid || slot_open;
  assign pend_mask  = slot_pend | (st_valid ? (ONE_HOT0 << st_id) : '0);
  assign req_ready  = (rst_n && stage_open) ? grant : '0;
  assign add_a      = st_a;
  assign add_b      = st_b;
  assign add_sub    = st_sub;
  assign load_id    = st_id;

  // Operand stage: filled on a request transfer, emptied when the slot takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= 1'b0;
      st_a     <= '0;
      st_b     <= '0;
      st_sub   <= 1'b0;
      st_id    <= '0;
    end else if (xfer) begin
      st_valid <= 1'b1;
      st_a     <= req_a[gnt_idx];
      st_b     <= req_b[gnt_idx];
      st_sub   <= req_sub[gnt_idx];
      st_id    <= gnt_idx;
    end else if (load) begin
      st_valid <= 1'b0;
    end
  end
`else
  assign load      = xfer;
  assign pend_mask = slot_pend;
  assign req_ready = (rst_n && slot_open) ? grant : '0;
  assign add_a     = req_a[gnt_idx];
  assign add_b     = req_b[gnt_idx];
  assign add_sub   = req_sub[gnt_idx];
  assign load_id   = gnt_idx;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (xfer),
    .grant   (grant),
    .idx     (gnt_idx)
  );

  fpAdder32 u_add (
    .a      (add_a),
    .b      (add_b),
    .op_sub (add_sub),
    .result (sum)
  );

  // Result slot: captures the adder output and holds it until the owner accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot     <= SLOT_EMPTY;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      case (slot)
        SLOT_EMPTY: begin
          if (load) begin
            slot     <= SLOT_FULL;
            rsp_data <= sum;
            rsp_id   <= load_id;
          end
        end
        SLOT_FULL: begin
          if (load) begin
            rsp_data <= sum;
            rsp_id   <= load_id;
          end else if (drain) begin
            slot <= SLOT_EMPTY;
          end
        end
        default: slot <= SLOT_EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_add_arbiter
// Description : Scoreboard bench for fp_add_arbiter: request transfers push
//               hand-computed results, a monitor pops on response transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_arbiter;
  import fp_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef FP_ADD_ARB_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
  logic [NREQ-1:0][31:0] req_a, req_b;
  fp32_t                 rsp_data;
  logic [IDW-1:0]        rsp_id;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] res;
    int          t;
    bit          chk_lat;
  } sb_t;

  vec_t            tbl [8];
  sb_t             q[$];
  sb_t             mon_e;
  int              vidx [NREQ];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  bit              front_seen = 1'b0;
  bit              lat_en = 1'b1;
  logic [NREQ-1:0] xf;

  fp_add_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_op(input int i, input int v);
    vidx[i]   = v;
    req_a[i]  = tbl[v].a;
    req_b[i]  = tbl[v].b;
    req_sub[i] = tbl[v].sub;
  endtask

  task automatic wait_xfer(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!(req_valid[i] && req_ready[i]) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 30) begin
      errors++;
      $display("FAIL xfer_timeout: requester %0d got no grant, expected one within 30 cycles", i);
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input int i, input int v);
    set_op(i, v);
    req_valid[i] = 1'b1;
    wait_xfer(i);
    req_valid[i] = 1'b0;
  endtask

  task automatic drain_wait();
    int n;
    n = 0;
    @(negedge clk);
    while ((q.size() != 0 || rsp_valid != '0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 30) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: response transfers pop and compare; request transfers push
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      check("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if (rsp_valid != '0) begin
        check("rsp_valid_vs_id", rsp_valid, 4'b0001 << rsp_id);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got id %0d data %h, expected no response", rsp_id, rsp_data);
        end else begin
          if (!front_seen && q[0].chk_lat) check("latency", cyc - q[0].t, LAT);
          front_seen = 1'b1;
          if (rsp_ready[rsp_id]) begin
            mon_e = q.pop_front();
            check("rsp_id", rsp_id, mon_e.id);
            check("rsp_data", rsp_data, mon_e.res);
            front_seen = 1'b0;
          end
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i])
          q.push_back('{id: i, res: tbl[vidx[i]].res, t: cyc, chk_lat: lat_en});
    end
  end

  initial begin
    tbl[0] = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000}; // 1+2=3
    tbl[1] = '{32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000}; // 3-1=2
    tbl[2] = '{32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000}; // 2+2=4
    tbl[3] = '{32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000}; // 1-1=+0
    tbl[4] = '{32'h4000_0000, 32'h4040_0000, 1'b1, 32'hBF80_0000}; // 2-3=-1
    tbl[5] = '{32'h3FC0_0000, 32'h3F00_0000, 1'b0, 32'h4000_0000}; // 1.5+0.5=2
    tbl[6] = '{32'h4040_0000, 32'h3F80_0000, 1'b0, 32'h4080_0000}; // 3+1=4
    tbl[7] = '{32'hBF80_0000, 32'h3F00_0000, 1'b0, 32'hBF00_0000}; // -1+0.5=-0.5
    req_a = '0;
    req_b = '0;
    req_sub = '0;
    rsp_ready = '1;
    for (int i = 0; i < NREQ; i++) vidx[i] = 0;

    // Reset values, with every requester asking
    rst_n = 1'b0;
    req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_req_ready", req_ready, 0);
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b1;

    // Single operations on assorted requesters
    issue(0, 0);
    drain_wait();
    issue(2, 1);
    drain_wait();
    issue(1, 2);
    issue(3, 3);
    issue(0, 4);
    issue(2, 5);
    issue(1, 7);
    drain_wait();

    // Backpressure on requester 1, others ready and requesting
    lat_en = 1'b0;
    rsp_ready = 4'b1101;
    set_op(1, 6);
    req_valid = 4'b0010;
    wait_xfer(1);
    set_op(0, 0);
    set_op(2, 1);
    set_op(3, 5);
    req_valid = 4'b1101;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (rsp_valid == '0 && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", rsp_valid, 4'b0010);
      check("bp_rsp_id", rsp_id, 1);
      check("bp_rsp_data", rsp_data, 32'h4080_0000);
      check("bp_req_ready", req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = '1;
    for (int k = 0; k < 20 && req_valid != '0; k++) begin
      @(negedge clk);
      xf = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~xf;
    end
    check("bp_all_granted", req_valid, 0);
    drain_wait();
    lat_en = 1'b1;

    // Reset one cycle after a transfer discards the held result
    rsp_ready = '0;
    set_op(3, 0);
    req_valid = 4'b1000;
    wait_xfer(3);
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    front_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("in_reset_rsp_valid", rsp_valid, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = '1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_rsp_valid", rsp_valid, 0);
    end
    @(posedge clk); #1;

    // All four continuously valid: strict rotation starting at 0, no gaps
    for (int i = 0; i < NREQ; i++) set_op(i, i);
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("rr_grant", req_ready, 4'b0001 << (k % 4));
      xf = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++)
        if (xf[i]) set_op(i, (vidx[i] + 1) % 8);
    end
    req_valid = '0;
    drain_wait();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
